// File: rtl/seq_pkg.sv
// Shared definitions for the sequence tracker: code words, FSM states and
// helpers that step through the six-code counting sequence.
package seq_pkg;

    localparam int NUM_CODES = 6;

    localparam logic [2:0] CODE_0 = 3'b000;
    localparam logic [2:0] CODE_1 = 3'b010;
    localparam logic [2:0] CODE_2 = 3'b100;
    localparam logic [2:0] CODE_3 = 3'b001;
    localparam logic [2:0] CODE_4 = 3'b111;
    localparam logic [2:0] CODE_5 = 3'b101;

    localparam logic [2:0] ILLEGAL_A = 3'b011;
    localparam logic [2:0] ILLEGAL_B = 3'b110;

    localparam logic [2:0] IDX_LAST    = 3'd5;
    localparam logic [2:0] IDX_UNKNOWN = 3'd7;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Index -> code word; out-of-range indices map to an illegal code so
    // they can never match a legal observation.
    function automatic logic [2:0] code_of(input logic [2:0] i);
        case (i)
            3'd0:    return CODE_0;
            3'd1:    return CODE_1;
            3'd2:    return CODE_2;
            3'd3:    return CODE_3;
            3'd4:    return CODE_4;
            3'd5:    return CODE_5;
            default: return ILLEGAL_A;
        endcase
    endfunction

    function automatic logic [2:0] next_code(input logic [2:0] code);
        case (code)
            CODE_0:  return CODE_1;
            CODE_1:  return CODE_2;
            CODE_2:  return CODE_3;
            CODE_3:  return CODE_4;
            CODE_4:  return CODE_5;
            CODE_5:  return CODE_0;
            default: return ILLEGAL_B;
        endcase
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i >= IDX_LAST) ? 3'd0 : i + 3'd1;
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational decoder: observed code word -> sequence index and legal flag.
// Illegal words (011, 110) return index 7.
module seq_decode
    import seq_pkg::*;
(
    input  logic [2:0] d,
    output logic [2:0] idx,
    output logic       legal
);

    logic [NUM_CODES-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CODES; gi++) begin : g_hit
            assign hit[gi] = (d == code_of(3'(gi)));
        end
    endgenerate

    always_comb begin
        idx   = IDX_UNKNOWN;
        legal = 1'b0;
        for (int i = 0; i < NUM_CODES; i++) begin
            if (hit[i]) begin
                idx   = 3'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_tracker.sv
// Tracks a 6-state counter sequence: hunts, acquires and flywheels through
// mismatches. Optional saturating error counter under SEQ_TRACKER_ERRCNT_EN.
module seq_tracker
    import seq_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int MISS_MAX = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [2:0] d,
    input  logic       valid,
    output logic [2:0] idx,
    output logic       lock,
    output logic       err,
    output logic       wrap,
    output logic [7:0] errcnt
);

    localparam logic [2:0] LOCK_V = 3'(LOCK_CNT);
    localparam logic [2:0] MISS_V = 3'(MISS_MAX);

    logic [2:0] d_idx;
    logic       d_legal;

    seq_decode u_decode (
        .d     (d),
        .idx   (d_idx),
        .legal (d_legal)
    );

    state_t     state_reg;
    logic [2:0] idx_reg;
    logic [2:0] match_reg;
    logic [2:0] miss_reg;
    logic       lock_reg;
    logic       err_reg;
    logic       wrap_reg;

    logic [2:0] succ_idx;
    logic       hit_succ;

    // idx_reg doubles as the reference position while in ACQ/LOCKED
    assign succ_idx = next_idx(idx_reg);
    assign hit_succ = (d == next_code(code_of(idx_reg)));

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg <= HUNT;
            idx_reg   <= IDX_UNKNOWN;
            match_reg <= 3'd0;
            miss_reg  <= 3'd0;
            lock_reg  <= 1'b0;
            err_reg   <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            err_reg  <= 1'b0;
            wrap_reg <= 1'b0;
            if (valid) begin
                case (state_reg)
                    HUNT: begin
                        if (d_legal) begin
                            state_reg <= ACQ;
                            idx_reg   <= d_idx;
                            match_reg <= 3'd0;
                        end
                    end
                    ACQ: begin
                        if (!d_legal) begin
                            state_reg <= HUNT;
                            idx_reg   <= IDX_UNKNOWN;
                            match_reg <= 3'd0;
                        end else if (hit_succ) begin
                            idx_reg <= succ_idx;
                            if (match_reg + 3'd1 == LOCK_V) begin
                                state_reg <= LOCKED;
                                lock_reg  <= 1'b1;
                                match_reg <= 3'd0;
                                miss_reg  <= 3'd0;
                            end else begin
                                match_reg <= match_reg + 3'd1;
                            end
                        end else begin
                            idx_reg   <= d_idx;
                            match_reg <= 3'd0;
                        end
                    end
                    LOCKED: begin
                        if (hit_succ) begin
                            idx_reg  <= succ_idx;
                            miss_reg <= 3'd0;
                            wrap_reg <= (idx_reg == IDX_LAST);
                        end else begin
                            // Flywheel: keep advancing as if the expected code arrived
                            err_reg <= 1'b1;
                            if (miss_reg + 3'd1 == MISS_V) begin
                                state_reg <= HUNT;
                                lock_reg  <= 1'b0;
                                idx_reg   <= IDX_UNKNOWN;
                                miss_reg  <= 3'd0;
                            end else begin
                                idx_reg  <= succ_idx;
                                miss_reg <= miss_reg + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= HUNT;
                        lock_reg  <= 1'b0;
                        idx_reg   <= IDX_UNKNOWN;
                        match_reg <= 3'd0;
                        miss_reg  <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign idx  = idx_reg;
    assign lock = lock_reg;
    assign err  = err_reg;
    assign wrap = wrap_reg;

`ifdef SEQ_TRACKER_ERRCNT_EN
    logic       mismatch;
    logic [7:0] errcnt_reg;

    assign mismatch = valid && (state_reg == LOCKED) && !hit_succ;

    always_ff @(posedge clk) begin
        if (!clr) begin
            errcnt_reg <= 8'd0;
        end else if (mismatch && (errcnt_reg != 8'hFF)) begin
            errcnt_reg <= errcnt_reg + 8'd1;
        end
    end

    assign errcnt = errcnt_reg;
`else
    assign errcnt = 8'd0;
`endif

endmodule

// File: tb/tb_seq_tracker.sv
// Scoreboard bench for seq_tracker: stimulus pushes expected outputs,
// a monitor pops and compares one clock after each sample.
module tb_seq_tracker;

    logic       clk = 1'b0;
    logic       clr;
    logic [2:0] d;
    logic       valid;
    logic [2:0] idx;
    logic       lock;
    logic       err;
    logic       wrap;
    logic [7:0] errcnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] idx;
        logic       lock;
        logic       err;
        logic       wrap;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t q[$];

    seq_tracker dut (
        .clk    (clk),
        .clr    (clr),
        .d      (d),
        .valid  (valid),
        .idx    (idx),
        .lock   (lock),
        .err    (err),
        .wrap   (wrap),
        .errcnt (errcnt)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    task automatic step(input logic c, input logic v, input logic [2:0] dv,
                        input logic [2:0] ei, input logic el, input logic ee,
                        input logic ew, input int ec, input string nm);
        exp_t e;
        @(negedge clk);
        clr   = c;
        valid = v;
        d     = dv;
        e.idx  = ei;
        e.lock = el;
        e.err  = ee;
        e.wrap = ew;
`ifdef SEQ_TRACKER_ERRCNT_EN
        e.cnt  = 8'(ec);
`else
        e.cnt  = (ec >= 0) ? 8'd0 : 8'd0;
`endif
        e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: every output sample is checked against the oldest expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (idx !== e.idx || lock !== e.lock || err !== e.err ||
                    wrap !== e.wrap || errcnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s got idx=%0d lock=%0d err=%0d wrap=%0d errcnt=%0d want idx=%0d lock=%0d err=%0d wrap=%0d errcnt=%0d",
                             e.name, idx, lock, err, wrap, errcnt,
                             e.idx, e.lock, e.err, e.wrap, e.cnt);
                end else begin
                    $display("ok   %s idx=%0d lock=%0d err=%0d wrap=%0d errcnt=%0d",
                             e.name, idx, lock, err, wrap, errcnt);
                end
            end
        end
    end

    initial begin : stimulus
        clr   = 1'b0;
        valid = 1'b0;
        d     = 3'b000;

        // Reset, with valid legal input ignored
        step(0, 1, 3'b000, 7, 0, 0, 0, 0, "reset0");
        step(0, 0, 3'b010, 7, 0, 0, 0, 0, "reset1");
        // Acquire: 000,010,100,001 -> lock at idx 3
        step(1, 1, 3'b000, 0, 0, 0, 0, 0, "acq0");
        step(1, 1, 3'b010, 1, 0, 0, 0, 0, "acq1");
        step(1, 1, 3'b100, 2, 0, 0, 0, 0, "acq2");
        step(1, 1, 3'b001, 3, 1, 0, 0, 0, "lock");
        // Wrap
        step(1, 1, 3'b111, 4, 1, 0, 0, 0, "run4");
        step(1, 1, 3'b101, 5, 1, 0, 0, 0, "run5");
        step(1, 1, 3'b000, 0, 1, 0, 1, 0, "wrap");
        step(1, 1, 3'b010, 1, 1, 0, 0, 0, "run1");
        // Illegal code while locked: flywheel to idx 2
        step(1, 1, 3'b011, 2, 1, 1, 0, 1, "illegal_err");
        step(1, 1, 3'b001, 3, 1, 0, 0, 1, "recover");
        // VALID low holds everything
        for (int i = 0; i < 5; i++)
            step(1, 0, 3'b110, 3, 1, 0, 0, 1, "hold");
        step(1, 1, 3'b111, 4, 1, 0, 0, 1, "run4b");
        step(1, 1, 3'b101, 5, 1, 0, 0, 1, "run5b");
        step(1, 1, 3'b000, 0, 1, 0, 1, 1, "wrapb");
        step(1, 1, 3'b010, 1, 1, 0, 0, 1, "run1b");
        step(1, 1, 3'b100, 2, 1, 0, 0, 1, "run2b");
        // Two consecutive misses -> lose lock
        step(1, 1, 3'b100, 3, 1, 1, 0, 2, "miss1");
        step(1, 1, 3'b100, 7, 0, 1, 0, 3, "miss2_hunt");
        // Illegal codes keep HUNT
        step(1, 1, 3'b011, 7, 0, 0, 0, 3, "hunt_ill_a");
        step(1, 1, 3'b110, 7, 0, 0, 0, 3, "hunt_ill_b");
        // ACQ restart on legal non-successor
        step(1, 1, 3'b100, 2, 0, 0, 0, 3, "acq_start");
        step(1, 1, 3'b100, 2, 0, 0, 0, 3, "acq_restart");
        step(1, 1, 3'b001, 3, 0, 0, 0, 3, "acq_m1");
        step(1, 1, 3'b111, 4, 0, 0, 0, 3, "acq_m2");
        step(1, 1, 3'b101, 5, 1, 0, 0, 3, "relock");
        // Repeat of reference is a miss; no wrap on flywheel 5->0
        step(1, 1, 3'b101, 0, 1, 1, 0, 4, "repeat_err");
        step(1, 0, 3'b000, 0, 1, 0, 0, 4, "err_drop");
        step(1, 1, 3'b010, 1, 1, 0, 0, 4, "miss_clear");
        step(1, 1, 3'b011, 2, 1, 1, 0, 5, "single_miss");
        // Reset mid-lock overrides valid data
        step(0, 1, 3'b001, 7, 0, 0, 0, 0, "reset_lock");
        // Illegal in ACQ -> HUNT
        step(1, 1, 3'b000, 0, 0, 0, 0, 0, "acq_a");
        step(1, 1, 3'b010, 1, 0, 0, 0, 0, "acq_b");
        step(1, 1, 3'b110, 7, 0, 0, 0, 0, "acq_illegal");
        // 300 forced mismatches: lock, then two misses per round
        for (int r = 0; r < 150; r++) begin
            step(1, 1, 3'b000, 0, 0, 0, 0, sat(2*r), "sat_a0");
            step(1, 1, 3'b010, 1, 0, 0, 0, sat(2*r), "sat_a1");
            step(1, 1, 3'b100, 2, 0, 0, 0, sat(2*r), "sat_a2");
            step(1, 1, 3'b001, 3, 1, 0, 0, sat(2*r), "sat_lock");
            step(1, 1, 3'b001, 4, 1, 1, 0, sat(2*r+1), "sat_e1");
            step(1, 1, 3'b001, 7, 0, 1, 0, sat(2*r+2), "sat_e2");
        end
        step(1, 0, 3'b000, 7, 0, 0, 0, 255, "sat_final");

        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d want pending=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
